// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Command-driven controller for a register-file / A,B operand
//                register / ALU / C,status datapath. Accepts one instruction
//                per valid/ready handshake and sequences the load, select,
//                write and ALU-operation strobes needed to execute it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int REGW  = 3,
    parameter int DATAW = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_type_i,
    input  logic [1:0]       cmd_aluop_i,
    input  logic [REGW-1:0]  cmd_rd_i,
    input  logic [REGW-1:0]  cmd_rn_i,
    input  logic [REGW-1:0]  cmd_rm_i,
    input  logic [DATAW-1:0] cmd_imm_i,
    output logic [REGW-1:0]  readnum_o,
    output logic [REGW-1:0]  writenum_o,
    output logic             write_o,
    output logic             loada_o,
    output logic             loadb_o,
    output logic             loadc_o,
    output logic             loads_o,
    output logic             asel_o,
    output logic             bsel_o,
    output logic             vsel_o,
    output logic [1:0]       ALUop_o,
    output logic [DATAW-1:0] datapath_in_o,
    output logic             done_o
);

    // Command encodings
    localparam logic [1:0] c_TYPE_ALU    = 2'b00;
    localparam logic [1:0] c_TYPE_CMP    = 2'b01;
    localparam logic [1:0] c_TYPE_MOVIMM = 2'b10;
    localparam logic [1:0] c_TYPE_MOVREG = 2'b11;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [1:0]       type_q;
    logic [1:0]       aluop_q;
    logic [REGW-1:0]  rd_q;
    logic [REGW-1:0]  rn_q;
    logic [REGW-1:0]  rm_q;
    logic [DATAW-1:0] imm_q;

    logic             accept_w;

    // Ready is a pure function of the state register, so accept only in IDLE
    assign accept_w = cmd_valid_i && (state_q == S_IDLE);

    // State register; reset aborts any command in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command field capture at the transfer edge; the immediate is kept only
    // for MOV #imm so datapath_in holds the most recent immediate
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            type_q  <= 2'b00;
            aluop_q <= 2'b00;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
        end else if (accept_w) begin
            type_q  <= cmd_type_i;
            aluop_q <= cmd_aluop_i;
            rd_q    <= cmd_rd_i;
            rn_q    <= cmd_rn_i;
            rm_q    <= cmd_rm_i;
            if (cmd_type_i == c_TYPE_MOVIMM) begin
                imm_q <= cmd_imm_i;
            end
        end
    end

    // Next-state selection: entry point depends on the command type
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_type_i)
                        c_TYPE_ALU,
                        c_TYPE_CMP:    state_d = S_GET_A;
                        c_TYPE_MOVIMM: state_d = S_WB;
                        default:       state_d = S_GET_B;
                    endcase
                end
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_EXEC;
            // CMP finishes in EXEC; it only updates status
            S_EXEC:  state_d = (type_q == c_TYPE_CMP) ? S_IDLE : S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register and latched fields only
    always_comb begin
        cmd_ready_o = 1'b0;
        readnum_o   = '0;
        writenum_o  = '0;
        write_o     = 1'b0;
        loada_o     = 1'b0;
        loadb_o     = 1'b0;
        loadc_o     = 1'b0;
        loads_o     = 1'b0;
        asel_o      = 1'b0;
        bsel_o      = 1'b0;
        vsel_o      = 1'b0;
        ALUop_o     = 2'b00;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
            end
            S_GET_A: begin
                readnum_o = rn_q;
                loada_o   = 1'b1;
            end
            S_GET_B: begin
                readnum_o = rm_q;
                loadb_o   = 1'b1;
            end
            S_EXEC: begin
                case (type_q)
                    c_TYPE_ALU: begin
                        ALUop_o = aluop_q;
                        loadc_o = 1'b1;
                        loads_o = 1'b1;
                    end
                    c_TYPE_CMP: begin
                        ALUop_o = c_OP_SUB;
                        loads_o = 1'b1;
                        done_o  = 1'b1;
                    end
                    default: begin
                        // MOV rd,rm: pass B through by zeroing A and adding
                        asel_o  = 1'b1;
                        ALUop_o = c_OP_ADD;
                        loadc_o = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                writenum_o = rd_q;
                vsel_o     = (type_q == c_TYPE_MOVIMM);
                write_o    = 1'b1;
                done_o     = 1'b1;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

    assign datapath_in_o = imm_q;

endmodule
`default_nettype wire
